// File: rtl/ins_fetch_51.sv
`default_nettype none
// ============================================================================
//  Module      : ins_fetch_51
//  Description : Instruction fetch stage. It reads one word per cycle from a
//                combinational instruction memory into a 2-entry {instr, pc}
//                FIFO, and it handles redirects and stop-fetch (halt).
//  Revision    : 1.0  initial release
// ============================================================================
module ins_fetch_51 #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h0000003F
) (
    input  logic        clk_51,
    input  logic        rst_n_51,
    output logic [31:0] raddr_51,
    input  logic [31:0] rdata_51,
    output logic [31:0] instr_51,
    output logic [31:0] ipc_51,
    output logic        valid_51,
    input  logic        ready_51,
    input  logic        redirect_51,
    input  logic [31:0] target_51,
    input  logic        halt_51,
    output logic [15:0] fetch_cnt_51
);

    // The PC is always word aligned, so the reset address is forced to alignment.
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, ipc0_q, ipc0_d;   // slot 0 is the head
    logic [31:0] instr1_q, instr1_d, ipc1_q, ipc1_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        pop_w;
    logic        push_w;
    logic        unused_tgt_lo;

    // The low target bits are dropped because redirects align down to a word.
    assign unused_tgt_lo = &{1'b0, target_51[1:0]};

    // Head of the FIFO is presented to decode. When the FIFO is empty, a NOP is shown at the current PC.
    assign raddr_51     = pc_q;
    assign valid_51     = (count_q != 2'd0);
    assign instr_51     = valid_51 ? instr0_q : NOP_WORD;
    assign ipc_51       = valid_51 ? ipc0_q   : pc_q;
    assign fetch_cnt_51 = fcnt_q;

    // Next-state logic: redirect overrides everything, else capture/pop/halt.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        instr0_d = instr0_q;
        ipc0_d   = ipc0_q;
        instr1_d = instr1_q;
        ipc1_d   = ipc1_q;
        fcnt_d   = fcnt_q;
        pop_w    = 1'b0;
        push_w   = 1'b0;

        if ((state_q != S_IDLE) && redirect_51) begin
            count_d = 2'd0;
            pc_d    = {target_51[31:2], 2'b00};
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   if (halt_51) state_d = S_HALT;
                default: state_d = state_q;
            endcase

            pop_w  = valid_51 && ready_51;
            push_w = (state_q == S_RUN) && !halt_51 && ((count_q != 2'd2) || pop_w);

            if (push_w) begin
                pc_d = pc_q + 32'd4;
                if (fcnt_q != 16'hFFFF) begin
                    fcnt_d = fcnt_q + 16'd1;
                end
            end

            case ({push_w, pop_w})
                2'b01: begin
                    instr0_d = instr1_q;
                    ipc0_d   = ipc1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_d = rdata_51;
                        ipc0_d   = pc_q;
                    end else begin
                        instr1_d = rdata_51;
                        ipc1_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_d = rdata_51;
                        ipc0_d   = pc_q;
                    end else begin
                        instr0_d = instr1_q;
                        ipc0_d   = ipc1_q;
                        instr1_d = rdata_51;
                        ipc1_d   = pc_q;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC, FIFO and counter registers with asynchronous reset.
    always_ff @(posedge clk_51 or negedge rst_n_51) begin
        if (!rst_n_51) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC_AL;
            count_q  <= 2'd0;
            instr0_q <= NOP_WORD;
            ipc0_q   <= 32'd0;
            instr1_q <= NOP_WORD;
            ipc1_q   <= 32'd0;
            fcnt_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            ipc0_q   <= ipc0_d;
            instr1_q <= instr1_d;
            ipc1_q   <= ipc1_d;
            fcnt_q   <= fcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_51.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_fetch_51
//  Description : Self-checking bench for ins_fetch_51, with a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ins_fetch_51;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP_WORD = 32'h0000003F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'd0;
    logic        halt = 1'b0;
    logic [15:0] fetch_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    ins_fetch_51 #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk_51      (clk),
        .rst_n_51    (rst_n),
        .raddr_51    (raddr),
        .rdata_51    (rdata),
        .instr_51    (instr),
        .ipc_51      (ipc),
        .valid_51    (valid),
        .ready_51    (ready),
        .redirect_51 (redirect),
        .target_51   (target),
        .halt_51     (halt),
        .fetch_cnt_51(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000003F;
        if (a == 32'h8) return 32'h00800684;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign rdata = memf(raddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of fetched {instr, pc}, mode 0=idle 1=run 2=halt.
    logic [63:0] mq[$];
    logic [31:0] m_pc   = RESET_PC;
    int          m_mode = 0;
    int          m_fcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_mode = 0;
            m_fcnt = 0;
        end else if (m_mode != 0 && redirect) begin
            mq.delete();
            m_pc   = {target[31:2], 2'b00};
            m_mode = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            bit do_pop;
            bit can_fetch;
            do_pop    = (mq.size() > 0) && ready;
            can_fetch = (m_mode == 1) && !halt;
            if (m_mode == 1 && halt) m_mode = 2;
            if (do_pop) void'(mq.pop_front());
            if (can_fetch && mq.size() < 2) begin
                mq.push_back({memf(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
                if (m_fcnt < 65535) m_fcnt++;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            logic        e_valid;
            logic [31:0] e_instr;
            logic [31:0] e_ipc;
            e_valid = (mq.size() > 0);
            e_instr = e_valid ? mq[0][63:32] : NOP_WORD;
            e_ipc   = e_valid ? mq[0][31:0]  : m_pc;
            check("model_valid", {31'd0, valid}, {31'd0, e_valid});
            check("model_instr", instr, e_instr);
            check("model_ipc", ipc, e_ipc);
            check("model_raddr", raddr, m_pc);
            check("model_fcnt", {16'd0, fetch_cnt}, m_fcnt[31:0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            ready    = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 19) == 0);
            halt     = ($urandom_range(0, 19) == 0);
            target   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15))
                                                   : $urandom;
            cyc();
        end
        redirect = 1'b0;
        halt     = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0000003F);
        check("rst_raddr", raddr, 32'h00000000);
        check("rst_fcnt", {16'd0, fetch_cnt}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Free-flowing fetch from address 0
        cyc();
        check("idle_valid", {31'd0, valid}, 32'd0);
        cyc();
        check("c2_valid", {31'd0, valid}, 32'd1);
        check("c2_instr", instr, 32'h0000003F);
        check("c2_ipc", ipc, 32'h0);
        cyc();
        check("c3_ipc", ipc, 32'h4);
        cyc();
        check("c4_ipc", ipc, 32'h8);
        check("c4_instr", instr, 32'h00800684);

        // Back-pressure from reset: buffer fills and PC freezes
        #2 rst_n = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("bp_raddr", raddr, 32'h8);
        check("bp_fcnt", {16'd0, fetch_cnt}, 32'd2);
        check("bp_ipc", ipc, 32'h0);
        ready = 1'b1;
        cyc();
        check("bp_ipc4", ipc, 32'h4);
        cyc();
        check("bp_ipc8", ipc, 32'h8);
        cyc();
        check("bp_ipcC", ipc, 32'hC);

        // Redirect with a full buffer
        ready = 1'b0;
        cyc();
        redirect = 1'b1;
        target   = 32'h0000001E;
        cyc();
        redirect = 1'b0;
        check("rd_valid0", {31'd0, valid}, 32'd0);
        check("rd_raddr", raddr, 32'h1C);
        cyc();
        check("rd_valid1", {31'd0, valid}, 32'd1);
        check("rd_ipc", ipc, 32'h1C);

        // Halt with two entries buffered, then drain
        cyc();
        halt = 1'b1;
        cyc();
        halt  = 1'b0;
        ready = 1'b1;
        cyc();
        check("h_ipc20", ipc, 32'h20);
        cyc();
        check("h_valid0", {31'd0, valid}, 32'd0);
        check("h_instr", instr, 32'h0000003F);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("h_raddr", raddr, 32'h24);
            check("h_valid", {31'd0, valid}, 32'd0);
        end
        redirect = 1'b1;
        target   = 32'h40;
        cyc();
        redirect = 1'b0;
        check("hr_raddr", raddr, 32'h40);
        cyc();
        check("hr_ipc", ipc, 32'h40);
        check("hr_valid", {31'd0, valid}, 32'd1);

        // PC wrap at the top of the address space
        redirect = 1'b1;
        target   = 32'hFFFFFFF8;
        cyc();
        redirect = 1'b0;
        cyc();
        check("w_ipcF8", ipc, 32'hFFFFFFF8);
        cyc();
        check("w_ipcFC", ipc, 32'hFFFFFFFC);
        cyc();
        check("w_ipc0", ipc, 32'h00000000);

        // Random traffic
        rand_run(1500);

        // Asynchronous reset with a full buffer
        ready    = 1'b0;
        halt     = 1'b0;
        redirect = 1'b1;
        target   = 32'h100;
        cyc();
        redirect = 1'b0;
        cyc();
        cyc();
        check("ar_valid_pre", {31'd0, valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, valid}, 32'd0);
        check("ar_raddr", raddr, 32'h0);
        check("ar_instr", instr, 32'h0000003F);
        check("ar_fcnt", {16'd0, fetch_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_run(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
